// File: rtl/lcd_fmt_pkg.sv
// Shared constants and FSM encoding for the LCD1602 number formatter.
// Optional feature macro used by the top: LCD_OVERFLOW_EN.
package lcd_fmt_pkg;

  localparam logic [7:0] SPACE = 8'h20;
  localparam logic [7:0] ZERO  = 8'h30;
  localparam logic [7:0] DASH  = 8'h2D;

  localparam int PREFIX_LEN = 5;
  localparam int UNIT_LEN   = 3;
  localparam int ROW_LEN    = 16;
  localparam int FRAME_LEN  = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    FILL   = 2'd2,
    COMMIT = 2'd3
  } state_t;

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD datapath, one bit per i_step cycle.
// o_ovf is sticky: set when a 1 falls off the top BCD nibble.
module bin2bcd_seq #(
  parameter int DATA_W = 27,
  parameter int DIGITS = 8
) (
  input  logic                  sys_clk,
  input  logic                  rst_n,
  input  logic                  i_load,
  input  logic [DATA_W-1:0]     i_data,
  input  logic                  i_step,
  output logic [4*DIGITS-1:0]   o_bcd,
  output logic                  o_ovf
);

  logic [DATA_W-1:0]   r_shreg;
  logic [4*DIGITS-1:0] r_bcd;
  logic                r_ovf;
  logic [4*DIGITS-1:0] w_adj;

  always_comb begin
    w_adj = r_bcd;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_bcd[4*k +: 4] >= 4'd5) begin
        w_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
      end
    end
  end

  // The bit leaving the top nibble carries a multiple of 10^DIGITS, so dropping it leaves value mod 10^DIGITS.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shreg <= '0;
      r_bcd   <= '0;
      r_ovf   <= 1'b0;
    end else if (i_load) begin
      r_shreg <= i_data;
      r_bcd   <= '0;
      r_ovf   <= 1'b0;
    end else if (i_step) begin
      r_bcd   <= {w_adj[4*DIGITS-2:0], r_shreg[DATA_W-1]};
      r_shreg <= {r_shreg[DATA_W-2:0], 1'b0};
      r_ovf   <= r_ovf | w_adj[4*DIGITS-1];
    end
  end

  assign o_bcd = r_bcd;
  assign o_ovf = r_ovf;

endmodule

// File: rtl/lcd_num_formatter.sv
// LCD1602 frame builder: sequential BCD conversion, blanking, double-buffered char readout.
// Define LCD_OVERFLOW_EN to show dashes and raise ovf when the value exceeds the digit field.
module lcd_num_formatter
  import lcd_fmt_pkg::*;
#(
  parameter int                        DATA_W = 27,
  parameter int                        DIGITS = 8,
  parameter logic [8*PREFIX_LEN-1:0]   PREFIX = "FREQ:",
  parameter logic [8*UNIT_LEN-1:0]     UNIT   = " Hz"
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  input  logic [4:0]        char_idx,
  output logic [7:0]        char_out
);

`ifdef LCD_OVERFLOW_EN
  localparam logic OVF_EN = 1'b1;
`else
  localparam logic OVF_EN = 1'b0;
`endif

  localparam int CNT_W = $clog2((DATA_W > DIGITS) ? DATA_W : DIGITS) + 1;

  state_t              r_state;
  state_t              w_next;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_pend_valid;
  logic [DATA_W-1:0]   r_pend_data;
  logic [7:0]          r_shadow [DIGITS];
  logic [7:0]          r_commit [DIGITS];
  logic                r_seen;
  logic                r_done;
  logic                r_ovf;

  logic                w_start;
  logic [DATA_W-1:0]   w_start_data;
  logic [4*DIGITS-1:0] w_bcd;
  logic                w_bcd_ovf;
  logic [3:0]          w_nib;
  logic                w_is_lsd;
  logic [7:0]          w_char;

  // A conversion can launch from IDLE or straight out of COMMIT; a fresh strobe beats the pending value.
  assign w_start      = ((r_state == IDLE) && data_valid) ||
                        ((r_state == COMMIT) && (data_valid || r_pend_valid));
  assign w_start_data = (r_state == COMMIT && !data_valid) ? r_pend_data : data_in;

  bin2bcd_seq #(
    .DATA_W (DATA_W),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .i_load  (w_start),
    .i_data  (w_start_data),
    .i_step  (r_state == CONV),
    .o_bcd   (w_bcd),
    .o_ovf   (w_bcd_ovf)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (data_valid) w_next = CONV;
      CONV:    if (r_cnt == CNT_W'(DATA_W - 1)) w_next = FILL;
      FILL:    if (r_cnt == CNT_W'(DIGITS - 1)) w_next = COMMIT;
      COMMIT:  w_next = w_start ? CONV : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_next != r_state) ? '0 : r_cnt + 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_valid <= 1'b0;
      r_pend_data  <= '0;
    end else if (r_state == COMMIT) begin
      r_pend_valid <= 1'b0;
    end else if (r_state != IDLE && data_valid) begin
      r_pend_valid <= 1'b1;
      r_pend_data  <= data_in;
    end
  end

  always_comb begin
    w_nib = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_cnt == CNT_W'(k)) w_nib = w_bcd[4*(DIGITS-1-k) +: 4];
    end
  end

  assign w_is_lsd = (r_cnt == CNT_W'(DIGITS - 1));

  always_comb begin
    w_char = SPACE;
    if (OVF_EN && w_bcd_ovf) w_char = DASH;
    else if (r_seen || w_nib != 4'd0 || w_is_lsd) w_char = ZERO + {4'b0000, w_nib};
  end

  // Shadow is filled MSD first; the committed copy only changes in COMMIT so readers never see a partial frame.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DIGITS; k++) begin
        r_shadow[k] <= (k == DIGITS - 1) ? ZERO : SPACE;
        r_commit[k] <= (k == DIGITS - 1) ? ZERO : SPACE;
      end
      r_seen <= 1'b0;
      r_done <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_done <= (r_state == COMMIT);
      if (w_start) r_seen <= 1'b0;
      else if (r_state == FILL && w_nib != 4'd0) r_seen <= 1'b1;
      if (r_state == FILL) begin
        for (int k = 0; k < DIGITS; k++) begin
          if (r_cnt == CNT_W'(k)) r_shadow[k] <= w_char;
        end
      end
      if (r_state == COMMIT) begin
        for (int k = 0; k < DIGITS; k++) r_commit[k] <= r_shadow[k];
        r_ovf <= OVF_EN & w_bcd_ovf;
      end
    end
  end

  always_comb begin
    char_out = SPACE;
    for (int k = 0; k < PREFIX_LEN; k++) begin
      if (char_idx == 5'(k)) char_out = PREFIX[8*(PREFIX_LEN-1-k) +: 8];
    end
    for (int k = 0; k < DIGITS; k++) begin
      if (char_idx == 5'(PREFIX_LEN + k)) char_out = r_commit[k];
    end
    for (int k = 0; k < UNIT_LEN; k++) begin
      if (char_idx == 5'(PREFIX_LEN + DIGITS + k)) char_out = UNIT[8*(UNIT_LEN-1-k) +: 8];
    end
  end

  assign busy = (r_state != IDLE);
  assign done = r_done;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_lcd_num_formatter.sv
// Randomized and directed bench for lcd_num_formatter against an arithmetic frame model.
// Honours LCD_OVERFLOW_EN for the expected overflow behaviour.
module tb_lcd_num_formatter;

  localparam int DATA_W = 27;
  localparam int DIGITS = 8;
  localparam longint MODV = 100000000;

`ifdef LCD_OVERFLOW_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic              sys_clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic              data_valid = 1'b0;
  logic [4:0]        char_idx = '0;
  logic              busy, done, ovf;
  logic [7:0]        char_out;

  int compared = 0;
  int mismatched = 0;
  int doneCount = 0;

  lcd_num_formatter dut (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .data_valid (data_valid),
    .busy       (busy),
    .done       (done),
    .ovf        (ovf),
    .char_idx   (char_idx),
    .char_out   (char_out)
  );

  always #50 sys_clk = ~sys_clk;

  always begin
    @(posedge sys_clk);
    #1;
    if (done) doneCount++;
  end

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Row 0 text the display should carry for value v.
  function automatic logic [127:0] expRow0(input longint v);
    string  s;
    string  field;
    longint m;
    logic [127:0] r;
    bit seen;
    s = "FREQ:";
    field = "";
    seen = 0;
    m = v % MODV;
    for (int k = 0; k < DIGITS; k++) begin
      longint p;
      int d;
      p = 1;
      for (int j = 0; j < DIGITS - 1 - k; j++) p = p * 10;
      d = int'((m / p) % 10);
      if (OVF_EN && v >= MODV) field = {field, "-"};
      else if (seen || d != 0 || k == DIGITS - 1) begin
        field = {field, string'(8'(8'h30 + d))};
        seen = 1;
      end else field = {field, " "};
    end
    s = {s, field, " Hz"};
    while (s.len() < 16) s = {s, " "};
    r = '0;
    for (int i = 0; i < 16; i++) r = {r[119:0], s[i]};
    return r;
  endfunction

  task automatic readRow(input int row, output logic [127:0] r);
    r = '0;
    for (int i = 0; i < 16; i++) begin
      char_idx = 5'(row * 16 + i);
      #1;
      r = {r[119:0], char_out};
    end
  endtask

  task automatic applyStimulus(input logic [DATA_W-1:0] v);
    @(negedge sys_clk);
    data_in = v;
    data_valid = 1'b1;
    @(negedge sys_clk);
    data_valid = 1'b0;
  endtask

  task automatic waitDone(input int limit, output bit got);
    int cyc;
    got = 0;
    cyc = 0;
    while (!got && cyc < limit) begin
      @(posedge sys_clk);
      #1;
      cyc++;
      if (done) got = 1;
    end
  endtask

  logic [127:0] row;
  logic [127:0] spaces = {16{8'h20}};
  bit got;
  int busyFirst, busyLast, doneAt, nDone, snap;
  logic [127:0] frameA, frameC;

  initial begin
    $display("[TB] start, overflow feature = %0d", OVF_EN);

    #120;
    checkOutput("reset_busy", 128'(busy), 128'(0));
    checkOutput("reset_done", 128'(done), 128'(0));
    checkOutput("reset_ovf", 128'(ovf), 128'(0));
    readRow(0, row);
    checkOutput("reset_row0", row, expRow0(0));
    readRow(1, row);
    checkOutput("reset_row1", row, spaces);
    @(negedge sys_clk);
    rst_n = 1'b1;

    // Latency and busy window for 1234567.
    @(negedge sys_clk);
    data_in = 27'd1234567;
    data_valid = 1'b1;
    busyFirst = -1; busyLast = -1; doneAt = -1; nDone = 0;
    for (int c = 1; c <= 45; c++) begin
      @(posedge sys_clk);
      #1;
      if (c == 1) data_valid = 1'b0;
      if (busy) begin
        if (busyFirst < 0) busyFirst = c;
        busyLast = c;
      end
      if (done) begin
        nDone++;
        if (doneAt < 0) doneAt = c;
      end
    end
    checkOutput("lat_done_cycle", 128'(doneAt), 128'(37));
    checkOutput("lat_done_pulses", 128'(nDone), 128'(1));
    checkOutput("lat_busy_first", 128'(busyFirst), 128'(1));
    checkOutput("lat_busy_last", 128'(busyLast), 128'(36));
    readRow(0, row);
    checkOutput("lat_row0", row, expRow0(1234567));
    readRow(1, row);
    checkOutput("lat_row1", row, spaces);

    // Directed boundary values then random ones.
    for (int i = 0; i < 22; i++) begin
      longint v;
      case (i)
        0: v = 0;
        1: v = 100;
        2: v = 123456789;
        3: v = 99999999;
        4: v = 100000000;
        5: v = 9;
        6: v = (64'd1 << DATA_W) - 1;
        default: v = (i % 2) ? longint'($urandom_range(0, 99999)) : longint'($urandom % (32'd1 << DATA_W));
      endcase
      applyStimulus(DATA_W'(v));
      waitDone(100, got);
      checkOutput($sformatf("val_done_%0d", v), 128'(got), 128'(1));
      readRow(0, row);
      checkOutput($sformatf("val_row0_%0d", v), row, expRow0(v));
      checkOutput($sformatf("val_ovf_%0d", v), 128'(ovf), 128'(OVF_EN && v >= MODV));
    end

    // Pending: A in cycle 0, B in cycle 3, C in cycle 10; B is overwritten.
    @(negedge sys_clk);
    data_in = 27'd5;
    data_valid = 1'b1;
    nDone = 0;
    frameA = '0;
    frameC = '0;
    for (int c = 1; c <= 150; c++) begin
      @(posedge sys_clk);
      #1;
      if (done) begin
        nDone++;
        if (nDone == 1) readRow(0, frameA);
        else readRow(0, frameC);
      end
      data_valid = (c == 3 || c == 10);
      if (c == 3) data_in = 27'd77;
      if (c == 10) data_in = 27'd9;
    end
    checkOutput("pend_done_pulses", 128'(nDone), 128'(2));
    checkOutput("pend_frame_a", frameA, expRow0(5));
    checkOutput("pend_frame_c", frameC, expRow0(9));

    // Strobe arriving in the COMMIT cycle must still be converted.
    @(negedge sys_clk);
    data_in = 27'd42;
    data_valid = 1'b1;
    snap = doneCount;
    for (int c = 1; c <= 120; c++) begin
      @(posedge sys_clk);
      #1;
      data_valid = (c == 36);
      if (c == 36) data_in = 27'd31415;
    end
    checkOutput("commit_strobe_pulses", 128'(doneCount - snap), 128'(2));
    readRow(0, row);
    checkOutput("commit_strobe_row0", row, expRow0(31415));

    // Reset mid-conversion with the pending slot full.
    applyStimulus(27'd555);
    repeat (4) @(negedge sys_clk);
    applyStimulus(27'd666);
    repeat (3) @(negedge sys_clk);
    #20;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_busy", 128'(busy), 128'(0));
    checkOutput("rst_done", 128'(done), 128'(0));
    readRow(0, row);
    checkOutput("rst_row0", row, expRow0(0));
    @(negedge sys_clk);
    rst_n = 1'b1;
    snap = doneCount;
    repeat (90) @(negedge sys_clk);
    checkOutput("rst_no_done", 128'(doneCount - snap), 128'(0));
    checkOutput("rst_idle_busy", 128'(busy), 128'(0));
    applyStimulus(27'd4321);
    waitDone(100, got);
    checkOutput("rst_after_done", 128'(got), 128'(1));
    readRow(0, row);
    checkOutput("rst_after_row0", row, expRow0(4321));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
